// File: rtl/fetch_entry_queue_pkg.sv
// Shared types for the fetch-entry queue: the frontend fetch entry layout
// (address, raw instruction, branch prediction, exception) and width helpers.
package fetch_entry_queue_pkg;

  localparam int unsigned VLEN = 64;

  typedef enum logic [2:0] {
    CF_NONE   = 3'd0,
    CF_BRANCH = 3'd1,
    CF_JUMP   = 3'd2,
    CF_JUMPR  = 3'd3,
    CF_RETURN = 3'd4
  } cf_t;

  typedef struct packed {
    cf_t             cf;
    logic [VLEN-1:0] predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [VLEN-1:0]    address;
    logic [31:0]        instruction;
    branchpredict_sbe_t branch_predict;
    exception_t         ex;
  } fetch_entry_t;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_entry_queue_ctrl.sv
// Pointer, count and fault-lock bookkeeping for the fetch-entry queue.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends combinationally on the opposite side's valid
// or ready, and flush_i suppresses every transfer in its cycle.
module fetch_entry_queue_ctrl
  import fetch_entry_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_valid_i,
  input  logic                       push_fault_i,
  input  logic                       pop_ready_i,
  output logic                       push_ready_o,
  output logic                       pop_valid_o,
  output logic                       replay_o,
  output logic                       push_fire_o,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr_o,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fault_lock_q;
  logic             full, empty, pop_fire;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Ready comes purely from registered state; the lock blocks everything after a fault.
  assign push_ready_o = !full && !fault_lock_q;
  assign pop_valid_o  = !empty;
  assign push_fire_o  = push_valid_i && push_ready_o && !flush_i;
  assign pop_fire     = pop_valid_o && pop_ready_i && !flush_i;
  // Entries dropped under the fault lock are discarded silently, not replayed.
  assign replay_o     = push_valid_i && !push_ready_o && !fault_lock_q && !flush_i;

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

  // Pointer/count/lock update; reset and flush both return to the empty, unlocked state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fault_lock_q <= 1'b0;
    end else begin
      if (push_fire_o) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_fire)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_fire_o && !pop_fire) count_q <= count_q + CNT_W'(1);
      else if (!push_fire_o && pop_fire) count_q <= count_q - CNT_W'(1);
      if (push_fire_o && push_fault_i) fault_lock_q <= 1'b1;
    end
  end

  a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_fire_o && full));
  a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_fire && empty));
  // A full queue has equal pointers, so the low count bits always match the pointer gap.
  a_count_ptrs   : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (count_q <= CNT_W'(DEPTH)) && (count_q[PTR_W-1:0] == PTR_W'(wr_ptr_q - rd_ptr_q)));

endmodule

// File: rtl/fetch_entry_queue.sv
// Fetch-entry queue: buffers fetch entries from the fetch path and presents
// them in order to decode; requests a replay when an entry arrives while full.
module fetch_entry_queue
  import fetch_entry_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  fetch_entry_t               push_entry_i,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  output logic                       replay_o,
  output logic [VLEN-1:0]            replay_addr_o,
  output fetch_entry_t               fetch_entry_o,
  output logic                       fetch_entry_valid_o,
  input  logic                       fetch_entry_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_fire;

  fetch_entry_queue_ctrl #(.DEPTH(DEPTH)) i_ctrl (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .push_valid_i (push_valid_i),
    .push_fault_i (push_entry_i.ex.valid),
    .pop_ready_i  (fetch_entry_ready_i),
    .push_ready_o (push_ready_o),
    .pop_valid_o  (fetch_entry_valid_o),
    .replay_o     (replay_o),
    .push_fire_o  (push_fire),
    .wr_ptr_o     (wr_ptr),
    .rd_ptr_o     (rd_ptr),
    .count_o      (occupancy_o)
  );

  // Storage write; contents need no reset since validity is tracked by the count.
  always_ff @(posedge clk_i) begin
    if (push_fire) mem_q[wr_ptr] <= push_entry_i;
  end

  assign fetch_entry_o = mem_q[rd_ptr];
  assign replay_addr_o = push_entry_i.address;

endmodule

// File: tb/tb_fetch_entry_queue.sv
// Bench for fetch_entry_queue: reference queue model with expected-address scoreboard.
module tb_fetch_entry_queue;
  import fetch_entry_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic                       clk_i = 1'b0;
  logic                       rst_ni;
  logic                       flush_i;
  fetch_entry_t               push_entry_i;
  logic                       push_valid_i;
  logic                       push_ready_o;
  logic                       replay_o;
  logic [VLEN-1:0]            replay_addr_o;
  fetch_entry_t               fetch_entry_o;
  logic                       fetch_entry_valid_o;
  logic                       fetch_entry_ready_i;
  logic [$clog2(DEPTH+1)-1:0] occupancy_o;

  logic [VLEN-1:0] exp_q[$];
  logic            exp_lock;
  int              n_checks = 0;
  int              n_pass   = 0;

  // Clock and watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  fetch_entry_queue #(.DEPTH(DEPTH)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .push_entry_i        (push_entry_i),
    .push_valid_i        (push_valid_i),
    .push_ready_o        (push_ready_o),
    .replay_o            (replay_o),
    .replay_addr_o       (replay_addr_o),
    .fetch_entry_o       (fetch_entry_o),
    .fetch_entry_valid_o (fetch_entry_valid_o),
    .fetch_entry_ready_i (fetch_entry_ready_i),
    .occupancy_o         (occupancy_o)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic fetch_entry_t mk_entry(input logic [63:0] addr, input logic exv);
    fetch_entry_t e;
    e             = '0;
    e.address     = addr;
    e.instruction = addr[31:0] ^ 32'h0000_0013;
    e.ex.valid    = exv;
    e.ex.cause    = exv ? 64'd1 : 64'd0;
    return e;
  endfunction

  // Drive one cycle starting just after a rising edge; checks combinational
  // outputs before the edge and registered state just after it.
  task automatic drive_cycle(input logic pv, input logic [63:0] addr, input logic exv,
                             input logic pr, input logic fl);
    logic        exp_ready, exp_push, exp_pop, exp_replay;
    logic [63:0] head;
    push_entry_i        = mk_entry(addr, exv);
    push_valid_i        = pv;
    fetch_entry_ready_i = pr;
    flush_i             = fl;
    #2;
    exp_ready  = (exp_q.size() != DEPTH) && !exp_lock;
    exp_replay = pv && !exp_ready && !exp_lock && !fl;
    check_val("push_ready", 64'(push_ready_o), 64'(exp_ready));
    check_val("replay", 64'(replay_o), 64'(exp_replay));
    if (exp_replay) check_val("replay_addr", replay_addr_o, addr);
    exp_pop  = pr && (exp_q.size() != 0) && !fl;
    exp_push = pv && exp_ready && !fl;
    if (exp_pop) begin
      head = exp_q.pop_front();
      check_val("pop_addr", fetch_entry_o.address, head);
    end
    if (exp_push) begin
      exp_q.push_back(addr);
      if (exv) exp_lock = 1'b1;
    end
    if (fl) begin
      exp_q.delete();
      exp_lock = 1'b0;
    end
    @(posedge clk_i);
    #1;
    push_valid_i        = 1'b0;
    fetch_entry_ready_i = 1'b0;
    flush_i             = 1'b0;
    check_val("valid", 64'(fetch_entry_valid_o), 64'(exp_q.size() != 0));
    check_val("occupancy", 64'(occupancy_o), 64'(exp_q.size()));
    if (exp_q.size() != 0) check_val("head_addr", fetch_entry_o.address, exp_q[0]);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      if (exp_q.size() != 0) drive_cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    end
    check_val("drained", 64'(fetch_entry_valid_o), 64'd0);
  endtask

  task automatic do_reset(input logic pv);
    rst_ni       = 1'b0;
    push_valid_i = pv;
    push_entry_i = mk_entry(64'h8000_0F00, 1'b0);
    @(posedge clk_i);
    #1;
    rst_ni       = 1'b1;
    push_valid_i = 1'b0;
    exp_q.delete();
    exp_lock = 1'b0;
    #2;
    check_val("rst_valid", 64'(fetch_entry_valid_o), 64'd0);
    check_val("rst_push_ready", 64'(push_ready_o), 64'd1);
    check_val("rst_occupancy", 64'(occupancy_o), 64'd0);
    check_val("rst_replay", 64'(replay_o), 64'd0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni              = 1'b0;
    flush_i             = 1'b0;
    push_valid_i        = 1'b0;
    fetch_entry_ready_i = 1'b0;
    push_entry_i        = '0;
    exp_lock            = 1'b0;
    @(posedge clk_i);
    #1;
    do_reset(1'b0);

    // Single push is visible the next cycle
    drive_cycle(1'b1, 64'h8000_0000, 1'b0, 1'b0, 1'b0);
    drain();

    // Fill to DEPTH, then a fifth push is refused and replayed
    for (int i = 0; i < 4; i++)
      drive_cycle(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 64'h8000_0010, 1'b0, 1'b0, 1'b0);

    // Full: push with pop pops only, then the retried push succeeds
    drive_cycle(1'b1, 64'h8000_0010, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b1, 64'h8000_0010, 1'b0, 1'b0, 1'b0);

    // Stream 10 entries across pointer wrap with random decode stalls
    for (int i = 0; i < 10; i++)
      drive_cycle(1'b1, 64'h8000_1000 + 64'(4 * i), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    drain();

    // Faulting entry locks out further pushes until a flush
    drive_cycle(1'b1, 64'h8000_2000, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 64'h8000_2004, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 64'h8000_2008, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b1, 64'h8000_200C, 1'b0, 1'b0, 1'b0);
    drain();

    // Flush overrides a simultaneous push and pop
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, 64'h8000_3000 + 64'(4 * i), 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 64'h8000_300C, 1'b0, 1'b1, 1'b1);

    // Reset with entries buffered empties the queue
    drive_cycle(1'b1, 64'h8000_4000, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 64'h8000_4004, 1'b0, 1'b0, 1'b0);
    do_reset(1'b1);

    // Random traffic against the model
    for (int i = 0; i < 40; i++)
      drive_cycle(1'($urandom_range(0, 1)), 64'h8000_5000 + 64'(4 * i),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) == 0));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_entry_queue.md
Name: fetch_entry_queue

Overview:
- Frontend-side producer of the fetch-entry handshake: buffers decoded-address fetch entries from the instruction-fetch path and presents them one at a time to the decode stage via valid/ready.
- Sits between the instruction cache/realign logic and the decode stage.
- Issues a replay request when an entry arrives while full, so the frontend re-fetches that address.
- Stops accepting entries after a faulting entry, until the next flush.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration (XLEN/VLEN widths via ariane_pkg types)
- DEPTH, 4, queue entries; power of two, >= 2

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- flush_i  in  1  discard all buffered entries and clear fault lock
- push_entry_i  in  ariane_pkg::fetch_entry_t  entry from fetch path (address, instruction, branch_predict, ex)
- push_valid_i  in  1  push_entry_i valid
- push_ready_o  out  1  queue can accept an entry this cycle
- replay_o  out  1  push dropped; frontend must re-fetch
- replay_addr_o  out  riscv::VLEN  address of dropped entry
- fetch_entry_o  out  ariane_pkg::fetch_entry_t  head entry to decode
- fetch_entry_valid_o  out  1  head entry valid
- fetch_entry_ready_i  in  1  decode accepts head this cycle
- occupancy_o  out  $clog2(DEPTH+1)  current entry count (perf/debug)

Behaviour:
- Storage: circular buffer of DEPTH entries; read/write pointers $clog2(DEPTH) bits wrap modulo DEPTH; count $clog2(DEPTH+1) bits.
- Reset: all state is cleared synchronously on rising clk_i when rst_ni==0. Pointers, count and fault lock go to 0.
  - Resulting outputs: fetch_entry_valid_o=0, push_ready_o=1, replay_o=0 (gated by push_valid_i), occupancy_o=0, fetch_entry_o=storage[0], which is don't-care while invalid.
  - Storage contents need no reset.
- push_ready_o = (count != DEPTH) && !fault_lock. It depends only on registered state; there is no combinational path from fetch_entry_ready_i.
- Push fires when push_valid_i && push_ready_o && !flush_i. The entry is written at the write pointer and the pointer increments.
- Pop fires when fetch_entry_valid_o && fetch_entry_ready_i && !flush_i. The read pointer increments.
- fetch_entry_valid_o = (count != 0). fetch_entry_o = storage[rd_ptr]; the read is combinational from registers.
- Latency: a pushed entry is visible at fetch_entry_o the cycle after the push. There is no same-cycle bypass.
- Simultaneous push and pop: both fire and count is unchanged. When count==DEPTH, push_ready_o=0, so a push is refused even if a pop occurs that cycle.
- Replay: replay_o = push_valid_i && !push_ready_o && !fault_lock && !flush_i. replay_addr_o = push_entry_i.address, and is valid only when replay_o=1.
- Fault lock: set on a push whose push_entry_i.ex.valid==1 (that entry is still enqueued). While the lock is set:
  - push_ready_o=0 and replay_o=0; further entries are silently dropped.
  - The lock clears only on flush_i or reset.
- Flush: in the cycle flush_i=1, no push or pop fires. On the next edge, pointers, count and fault lock clear, so fetch_entry_valid_o=0 the following cycle. flush_i overrides all other events in the same cycle.
- Reset while entries are buffered behaves identically to flush, and also clears storage pointers.
- occupancy_o = count (registered).
- Assertions (simulation only):
  - no push when full;
  - no pop when empty;
  - count == (wr_ptr - rd_ptr) mod DEPTH, except that count==DEPTH corresponds to equal pointers.

Decomposition:
- ariane_pkg already supplies fetch_entry_t; no new package types are required.
- Add a local constant for the count width, $clog2(DEPTH+1).
- One natural sub-module, fetch_entry_queue_ctrl, holds the pointers, count, fault lock and full/empty logic. The parent instantiates it alongside the storage array.
- The sub-module is optional, since total RTL stays near 150 lines.

Test Plan:
- Reset, then push A at 0x80000000 in one cycle -> fetch_entry_valid_o=1 the next cycle, fetch_entry_o.address=0x80000000, occupancy_o=1.
- Push 4 entries with fetch_entry_ready_i=0, then push a 5th at 0x80000010 -> push_ready_o=0 and replay_o=1 with replay_addr_o=0x80000010; occupancy_o stays 4.
- Full queue, then assert push_valid_i and fetch_entry_ready_i together -> pop only, occupancy_o=3. Next cycle push_ready_o=1 and the push succeeds; FIFO order is preserved across pointer wrap after 10 streamed entries.
- Push an entry with ex.valid=1, then 2 more -> only the faulting entry is enqueued; push_ready_o=0 and replay_o=0. After flush_i, push_ready_o=1.
- 3 entries buffered, then flush_i together with push_valid_i and fetch_entry_ready_i -> nothing pushed or popped; next cycle fetch_entry_valid_o=0 and occupancy_o=0.
- Pull rst_ni low for 1 cycle with 2 entries buffered -> next cycle fetch_entry_valid_o=0, push_ready_o=1, occupancy_o=0.
